// File: rtl/uart_pkg.sv
// UART types and constants shared by the transmitter and the receiver.
package uart_pkg;

  localparam int   DATA_BITS              = 8;
  localparam int   CLOCKS_PER_BIT_DEFAULT = 87;
  localparam logic IDLE_LEVEL             = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLOCKS_PER_BIT-1 and wraps; bitEnd is high on the last count.
// Clear (or reset) holds the count at 0, so the first bit after clear is a full period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_bitEnd
);

  localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_bitEnd = (r_count == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; one byte per valid/ready handshake, line falls one cycle after acceptance.
// Ready only in IDLE, so a held txValid waits out the frame. UART_TX_PARITY_EN adds an even-parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEFAULT
) (
  input  logic       clkTx,
  input  logic       rst,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  output logic       serialOutput,
  output logic       txBusy,
  output logic       txDone
);

  uart_state_t          r_state;
  uart_state_t          w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit_idx;
  logic                 r_serial;
  logic                 r_busy;
  logic                 r_done;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic w_bit_end;
  logic w_xfer;
  logic w_timer_clr;
  logic w_serial_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;

  assign txReady     = (r_state == IDLE) && !rst;
  assign w_xfer      = txValid && txReady;
  assign w_timer_clr = (r_state == IDLE);

  uart_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clkTx),
    .rst     (rst),
    .i_clear (w_timer_clr),
    .o_bitEnd(w_bit_end)
  );

  always_ff @(posedge clkTx) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_xfer) w_state_nxt = START;
      START: if (w_bit_end) w_state_nxt = DATA;
      DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_bit_end) w_state_nxt = STOP;
`endif
      STOP:  if (w_bit_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Decoded levels are registered below, so the line lags the state by one cycle.
  always_comb begin
    w_serial_nxt = IDLE_LEVEL;
    w_busy_nxt   = 1'b1;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE:  w_busy_nxt = 1'b0;
      START: w_serial_nxt = 1'b0;
      DATA:  w_serial_nxt = r_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: w_serial_nxt = r_parity;
`endif
      STOP:  w_done_nxt = w_bit_end;
      default: w_busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clkTx) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_idx <= 3'd0;
      r_serial  <= IDLE_LEVEL;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_serial <= w_serial_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      if (w_xfer) begin
        r_shift  <= txData;
`ifdef UART_TX_PARITY_EN
        r_parity <= even_parity(txData);
`endif
      end
      if ((r_state == START) && w_bit_end) begin
        r_bit_idx <= 3'd0;
      end
      if ((r_state == DATA) && w_bit_end) begin
        r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  assign serialOutput = r_serial;
  assign txBusy       = r_busy;
  assign txDone       = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, framing, back-to-back pitch, data stability, mid-frame reset, parity.
module tb_uart_tx;

  localparam int CPB = 87;
`ifdef UART_TX_PARITY_EN
  localparam int NB    = 11;
  localparam int PITCH = 958;
`else
  localparam int NB    = 10;
  localparam int PITCH = 871;
`endif

  logic       clkTx = 1'b0;
  logic       rst;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic       serialOutput;
  logic       txBusy;
  logic       txDone;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clkTx       (clkTx),
    .rst         (rst),
    .txData      (txData),
    .txValid     (txValid),
    .txReady     (txReady),
    .serialOutput(serialOutput),
    .txBusy      (txBusy),
    .txDone      (txDone)
  );

  always #5 clkTx = ~clkTx;
  always @(posedge clkTx) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a byte, wait (bounded) for ready, complete the handshake edge, then drop valid.
  task automatic handshake(input logic [7:0] b, input logic [7:0] after);
    int n;
    n = 0;
    @(negedge clkTx);
    txData  = b;
    txValid = 1'b1;
    while (!txReady && n < 5000) begin
      @(negedge clkTx);
      n++;
    end
    check("hs_wait", 32'(n < 5000), 1);
    @(posedge clkTx);
    #1;
    txValid = 1'b0;
    txData  = after;
  endtask

  // Called just after the handshake edge; walks the whole frame cycle by cycle.
  task automatic check_frame(input logic [7:0] b, input string tag,
                             output logic [7:0] rx, output logic rxp, output int start_cyc);
    logic [NB-1:0] lv;
    int dn, dc, bz, bn, pos;
`ifdef UART_TX_PARITY_EN
    lv = {1'b1, ^b, b, 1'b0};
`else
    lv = {1'b1, b, 1'b0};
`endif
    dn = 0; dc = -1; bz = 0; rx = 8'h00; rxp = 1'b0; start_cyc = 0;
    for (int c = 0; c <= NB*CPB; c++) begin
      @(negedge clkTx);
      if (txDone) begin
        dn++;
        dc = c;
      end
      if (c == 0) begin
        check({tag, "_lat"},   32'(serialOutput), 1);
        check({tag, "_busy0"}, 32'(txBusy), 0);
      end else begin
        bn  = (c - 1) / CPB;
        pos = (c - 1) % CPB;
        if (c == 1) start_cyc = cyc;
        if (!txBusy) bz++;
        if (pos == 0 || pos == CPB - 1)
          check($sformatf("%s_bit%0d_p%0d", tag, bn, pos), 32'(serialOutput), 32'(lv[bn]));
        if (pos == CPB / 2) begin
          if (bn >= 1 && bn <= 8) rx[bn-1] = serialOutput;
          if (bn == 9 && NB == 11) rxp = serialOutput;
        end
        if (c == 5*CPB) check({tag, "_rdy_mid"}, 32'(txReady), 0);
      end
    end
    check({tag, "_done_cnt"}, 32'(dn), 1);
    check({tag, "_done_cyc"}, 32'(dc), 32'(NB*CPB));
    check({tag, "_busy_gap"}, 32'(bz), 0);
  endtask

  initial begin
    logic [7:0] rx;
    logic       rxp;
    int         s1, s2, s;

    // Reset held 3 cycles with a pending byte
    rst     = 1'b1;
    txValid = 1'b1;
    txData  = 8'h12;
    repeat (3) begin
      @(negedge clkTx);
      check("rst_ready", 32'(txReady), 0);
      check("rst_line",  32'(serialOutput), 1);
      check("rst_busy",  32'(txBusy), 0);
      check("rst_done",  32'(txDone), 0);
    end
    rst = 1'b0;
    #1;
    check("rdy_after_rst", 32'(txReady), 1);
    txValid = 1'b0;
    @(negedge clkTx);
    check("no_hs_line", 32'(serialOutput), 1);
    check("no_hs_busy", 32'(txBusy), 0);
    check("no_hs_rdy",  32'(txReady), 1);

    // Single byte 0x55
    handshake(8'h55, 8'h55);
    check_frame(8'h55, "f55", rx, rxp, s);
    check("rx_55", 32'(rx), 32'h55);

    // Back-to-back 0xA5 then 0x3C with txValid held
    @(negedge clkTx);
    txData  = 8'hA5;
    txValid = 1'b1;
    check("b2b_rdy0", 32'(txReady), 1);
    @(posedge clkTx);
    #1;
    txData = 8'h3C;
    check_frame(8'hA5, "fA5", rx, rxp, s1);
    check("rx_A5", 32'(rx), 32'hA5);
    check("b2b_rdy1", 32'(txReady), 1);
    @(posedge clkTx);
    #1;
    txValid = 1'b0;
    check_frame(8'h3C, "f3C", rx, rxp, s2);
    check("rx_3C", 32'(rx), 32'h3C);
    check("b2b_pitch", 32'(s2 - s1), 32'(PITCH));

    // Data changed right after acceptance must not affect the frame
    handshake(8'h00, 8'hFF);
    check_frame(8'h00, "f00", rx, rxp, s);
    check("rx_00", 32'(rx), 32'h00);

    // Reset during data bit 3 of 0xC3
    handshake(8'hC3, 8'hC3);
    repeat (4*CPB + 40) @(negedge clkTx);
    check("mid_bit3_low", 32'(serialOutput), 0);
    rst = 1'b1;
    @(negedge clkTx);
    check("mid_rst_line", 32'(serialOutput), 1);
    check("mid_rst_done", 32'(txDone), 0);
    check("mid_rst_rdy",  32'(txReady), 0);
    check("mid_rst_busy", 32'(txBusy), 0);
    rst = 1'b0;
    @(negedge clkTx);
    check("mid_post_rdy",  32'(txReady), 1);
    check("mid_post_line", 32'(serialOutput), 1);
    check("mid_post_done", 32'(txDone), 0);
    handshake(8'h81, 8'h81);
    check_frame(8'h81, "f81", rx, rxp, s);
    check("rx_81", 32'(rx), 32'h81);

`ifdef UART_TX_PARITY_EN
    handshake(8'h07, 8'h07);
    check_frame(8'h07, "f07", rx, rxp, s);
    check("rx_07", 32'(rx), 32'h07);
    check("par_07", 32'(rxp), 1);
    handshake(8'h03, 8'h03);
    check_frame(8'h03, "f03", rx, rxp, s);
    check("rx_03", 32'(rx), 32'h03);
    check("par_03", 32'(rxp), 0);
`endif

    repeat (3) @(negedge clkTx);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
